bit_serial_alu_ctrl: RTL and testbench
======================================

Name: bit_serial_alu_ctrl

Overview:
Sequencer that sits directly upstream and downstream of the team's 1-bit ALU slice. It accepts WIDTH-bit operands and an opcode, then drives the slice one bit per clock, LSB first, through the slice's 5-bit control word. It chains the carry/borrow between cycles, collects the result bits in a shift register, and reports the WIDTH-bit result with zero, carry and overflow flags.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  00 add, 01 sub, 10 AND, 11 OR
inv  in  1  invert select; with op 10/11 gives NAND/NOR; must be 0 for add/sub
a  in  WIDTH  operand A, latched on accepted start
b  in  WIDTH  operand B, latched on accepted start
busy  out  1  high while a computation is in flight
done  out  1  one-cycle pulse; result and flags valid from this cycle
result  out  WIDTH  result, held until the next accepted start
zero  out  1  result == 0
carry  out  1  final carry-out (add) or borrow-out (sub); 0 for logic ops
overflow  out  1  signed overflow (add/sub); 0 for logic ops
alu_a  out  1  operand A bit to the slice
alu_b  out  1  operand B bit to the slice
alu_control  out  5  slice control word: [4:3]=op, [2]=inv, [1]=carry/borrow-in, [0]=shift-left (always 0)
alu_out  in  1  result bit from the slice (combinational)
alu_cout  in  1  carry-out (add) / borrow-out (sub) from the slice

Behaviour:
- Slice contract: add gives out=a^b^cin and cout=maj(a,b,cin). Sub gives out=a^b^bin and bout=(~a&b)|(~(a^b)&bin). The slice is combinational; its output is sampled in the same cycle.
- FSM states: IDLE, RUN, DONE.
- Reset: FSM enters IDLE; counter = 0; carry register = 0.
- Outputs after reset: busy, done, result, zero, carry, overflow, alu_a, alu_b and alu_control are all 0.
- IDLE:
  - start=1: latch a, b, op, inv into shift/holding registers; clear carry register and counter; go to RUN next cycle.
  - start=0: stay in IDLE.
- RUN, cycle k (k = 0..WIDTH-1):
  - Drive alu_a = A[k], alu_b = B[k], alu_control = {op, inv, creg, 0}.
  - Shift alu_out into the result register from the MSB side, so that after WIDTH cycles result[k] = bit k.
  - For add/sub: creg <= alu_cout. For logic ops: creg stays 0.
  - At k = WIDTH-1, also capture: carry <= alu_cout; overflow <= creg_in_at_MSB XOR alu_cout (add/sub only). Then go to DONE.
- DONE:
  - done = 1 for exactly one cycle.
  - zero is computed from the final result.
  - Return to IDLE next cycle.
- Busy and latency:
  - busy is 1 in RUN and DONE.
  - With start accepted at edge 0, done is high during cycle WIDTH+1.
- Start handling:
  - start while busy is ignored; it is not queued.
  - start in the DONE cycle is also ignored.
  - start in IDLE on the cycle immediately after DONE is accepted.
- Result hold: result and flags hold their values through IDLE until the next accepted start. On that start they are not cleared until they are overwritten at the end of the new run.
- Idle drive: alu_* outputs are 0 in IDLE and DONE.
- Reset mid-operation: abort immediately; no done pulse; all outputs return to their reset values.
- Invalid combination: inv=1 with add/sub is passed through to the slice unchanged; the result is unspecified and the bench does not check it.

Optional Feature:
BIT_SERIAL_CMP_EN
- Defined: extra output a_gt_b (1 bit, reset 0), valid with done and held like result. It gives the unsigned comparison A > B, computed serially LSB first with gt <= (A[k]&~B[k]) | (gt & ~(A[k]^B[k])). It is computed for every op, independent of the slice.
- Undefined: the port and its logic are absent.

Test Plan:
- Reset 3 cycles, then idle -> all outputs 0, busy 0, no done.
- add 0x0F + 0x01 (WIDTH=8) -> result 0x10, carry 0, overflow 0, zero 0; done high exactly 9 cycles after the start edge. add 0x7F + 0x01 -> 0x80, overflow 1, carry 0. add 0xFF + 0x01 -> 0x00, zero 1, carry 1, overflow 0.
- sub 0x05 - 0x05 -> 0x00, zero 1, carry 0. sub 0x03 - 0x05 -> 0xFE, carry (borrow) 1, overflow 0. sub 0x80 - 0x01 -> 0x7F, overflow 1.
- Logic ops: AND 0xF0, 0xCC -> 0xC0; op 10 with inv=1 (NAND) -> 0x3F; op 11 with inv=1 (NOR) on 0xF0, 0x0C -> 0x03. carry and overflow are 0 in all three cases.
- start pulsed at RUN cycles 2 and 5, and again in the DONE cycle -> ignored; exactly one done; result is from the first operands.
- reset asserted at RUN cycle 4 -> next cycle busy 0 and result 0; no done. With BIT_SERIAL_CMP_EN, compare 0x81 vs 0x7F -> a_gt_b 1; 0x7F vs 0x7F -> 0.

Source files
------------

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer around a 1-bit ALU slice: feeds operands LSB first, chains carry/borrow,
// and reports a WIDTH-bit result with flags. Optional serial A>B compare: BIT_SERIAL_CMP_EN.
module bit_serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             inv,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
`ifdef BIT_SERIAL_CMP_EN
   output logic             a_gt_b,
`endif
   output logic             alu_a,
   output logic             alu_b,
   output logic [4:0]       alu_control,
   input  logic             alu_out,
   input  logic             alu_cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] sh;
   logic [WIDTH-1:0] sh_nx;
   logic [1:0]       op_r;
   logic             inv_r;
   logic             creg;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             arith;
`ifdef BIT_SERIAL_CMP_EN
   logic             gt;
   logic             gt_nx;
`endif

   assign last  = (cnt == CW'(WIDTH - 1));
   assign arith = ~op_r[1];
   // Result bits enter from the MSB side so bit k lands at position k after WIDTH shifts.
   assign sh_nx = {alu_out, sh};
`ifdef BIT_SERIAL_CMP_EN
   assign gt_nx = (a_sh[0] & ~b_sh[0]) | (gt & ~(a_sh[0] ^ b_sh[0]));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      busy        = 1'b0;
      done        = 1'b0;
      alu_a       = 1'b0;
      alu_b       = 1'b0;
      alu_control = 5'd0;
      case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_RUN;
         end
         ST_RUN: begin
            busy        = 1'b1;
            alu_a       = a_sh[0];
            alu_b       = b_sh[0];
            alu_control = {op_r, inv_r, creg, 1'b0};
            if (last) state_nx = ST_DONE;
         end
         ST_DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh     <= '0;
         b_sh     <= '0;
         sh       <= '0;
         op_r     <= 2'd0;
         inv_r    <= 1'b0;
         creg     <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         overflow <= 1'b0;
`ifdef BIT_SERIAL_CMP_EN
         gt       <= 1'b0;
         a_gt_b   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  op_r  <= op;
                  inv_r <= inv;
                  creg  <= 1'b0;
                  cnt   <= '0;
                  sh    <= '0;
`ifdef BIT_SERIAL_CMP_EN
                  gt    <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               sh   <= sh_nx[WIDTH-1:1];
               creg <= arith & alu_cout;
               cnt  <= cnt + CW'(1);
`ifdef BIT_SERIAL_CMP_EN
               gt   <= gt_nx;
`endif
               // creg still holds the carry into the MSB here, which is what signed overflow needs.
               if (last) begin
                  result   <= sh_nx;
                  zero     <= ~|sh_nx;
                  carry    <= arith & alu_cout;
                  overflow <= arith & (creg ^ alu_cout);
`ifdef BIT_SERIAL_CMP_EN
                  a_gt_b   <= gt_nx;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed bench for bit_serial_alu_ctrl with a behavioural 1-bit slice and a result scoreboard.
module tb_bit_serial_alu_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset, start, inv;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, zero, carry, overflow;
   logic [W-1:0] result;
   logic         alu_a, alu_b, alu_out, alu_cout;
   logic [4:0]   alu_control;
`ifdef BIT_SERIAL_CMP_EN
   logic         a_gt_b;
`endif

   int           pass_cnt = 0;
   int           total_cnt = 0;
   // Packed as {gt, zero, carry, overflow, result}.
   logic [W+3:0] exp_q[$];
   logic [W-1:0] last_res;

   always #5 clk = ~clk;

   bit_serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .inv(inv), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .zero(zero), .carry(carry), .overflow(overflow),
`ifdef BIT_SERIAL_CMP_EN
      .a_gt_b(a_gt_b),
`endif
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_out(alu_out), .alu_cout(alu_cout)
   );

   // Behavioural model of the combinational ALU slice.
   always_comb begin
      alu_out  = 1'b0;
      alu_cout = 1'b0;
      case (alu_control[4:3])
         2'b00: begin
            alu_out  = alu_a ^ alu_b ^ alu_control[1];
            alu_cout = (alu_a & alu_b) | (alu_a & alu_control[1]) | (alu_b & alu_control[1]);
         end
         2'b01: begin
            alu_out  = alu_a ^ alu_b ^ alu_control[1];
            alu_cout = (~alu_a & alu_b) | (~(alu_a ^ alu_b) & alu_control[1]);
         end
         2'b10:   alu_out = (alu_a & alu_b) ^ alu_control[2];
         default: alu_out = (alu_a | alu_b) ^ alu_control[2];
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [W+3:0] ref_calc(input logic [1:0] o, input logic iv,
                                             input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0]   wide;
      logic [W-1:0] r;
      logic         c, v;
      c = 1'b0;
      v = 1'b0;
      case (o)
         2'b00: begin
            wide = {1'b0, x} + {1'b0, y};
            r = wide[W-1:0];
            c = wide[W];
            v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
         end
         2'b01: begin
            r = x - y;
            c = (x < y);
            v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
         end
         2'b10:   r = iv ? ~(x & y) : (x & y);
         default: r = iv ? ~(x | y) : (x | y);
      endcase
      return {(x > y), (r == '0), c, v, r};
   endfunction

   task automatic run_and_check(input logic [1:0] o, input logic iv,
                                input logic [W-1:0] x, input logic [W-1:0] y);
      int           n;
      logic [W+3:0] e;
      @(negedge clk);
      start = 1'b1; op = o; inv = iv; a = x; b = y;
      exp_q.push_back(ref_calc(o, iv, x, y));
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check("busy_run", busy, 1);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 4) check("result_held", result, last_res);
      end
      if (!done) begin
         check("done_timeout", done, 1);
      end else begin
         check("latency", n, W + 1);
         e = exp_q.pop_front();
         check("result", result, e[W-1:0]);
         check("overflow", overflow, e[W]);
         check("carry", carry, e[W+1]);
         check("zero", zero, e[W+2]);
`ifdef BIT_SERIAL_CMP_EN
         check("a_gt_b", a_gt_b, e[W+3]);
`endif
         check("alu_ctl_done", alu_control, 0);
         last_res = e[W-1:0];
         @(negedge clk);
         check("done_pulse", done, 0);
         check("busy_idle", busy, 0);
      end
   endtask

   initial begin
      int           n;
      int           done_cnt;
      logic [W+3:0] e;
      reset = 1'b1; start = 1'b0; op = 2'b00; inv = 1'b0; a = '0; b = '0;
      last_res = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_flags", {zero, carry, overflow}, 0);
      check("rst_alu", {alu_a, alu_b, alu_control}, 0);

      run_and_check(2'b00, 1'b0, 8'h0F, 8'h01);
      run_and_check(2'b00, 1'b0, 8'h7F, 8'h01);
      run_and_check(2'b00, 1'b0, 8'hFF, 8'h01);
      run_and_check(2'b01, 1'b0, 8'h05, 8'h05);
      run_and_check(2'b01, 1'b0, 8'h03, 8'h05);
      run_and_check(2'b01, 1'b0, 8'h80, 8'h01);
      run_and_check(2'b10, 1'b0, 8'hF0, 8'hCC);
      run_and_check(2'b10, 1'b1, 8'hF0, 8'hCC);
      run_and_check(2'b11, 1'b1, 8'hF0, 8'h0C);
      for (int i = 0; i < 4; i++) begin
         run_and_check(2'($urandom_range(0, 3)), 1'b0, W'($urandom_range(0, 255)),
                       W'($urandom_range(0, 255)));
      end
`ifdef BIT_SERIAL_CMP_EN
      run_and_check(2'b10, 1'b0, 8'h81, 8'h7F);
      run_and_check(2'b11, 1'b0, 8'h7F, 8'h7F);
`endif

      // Starts during RUN cycles 2 and 5 and in the DONE cycle must be dropped.
      @(negedge clk);
      start = 1'b1; op = 2'b00; inv = 1'b0; a = 8'h21; b = 8'h13;
      exp_q.push_back(ref_calc(2'b00, 1'b0, 8'h21, 8'h13));
      @(negedge clk);
      start = 1'b0;
      n = 1;
      done_cnt = 0;
      while (n < 13) begin
         start = 1'b0;
         if (n == 3 || n == 6 || done) begin
            start = 1'b1; op = 2'b01; a = 8'hAA; b = 8'h55;
         end
         if (done) begin
            done_cnt++;
            e = exp_q.pop_front();
            check("ign_result", result, e[W-1:0]);
            check("ign_flags", {zero, carry, overflow}, {e[W+2], e[W+1], e[W]});
            last_res = e[W-1:0];
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("ign_done_count", done_cnt, 1);
      check("ign_busy_after", busy, 0);

      // Reset asserted during RUN cycle 4 aborts without a done pulse.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 8'h12; b = 8'h34;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (n < 5) begin
         @(negedge clk);
         n++;
      end
      check("pre_abort_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_flags", {zero, carry, overflow}, 0);
      check("abort_alu", {alu_a, alu_b, alu_control}, 0);
      reset = 1'b0;
      done_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);
      check("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
